// File: rtl/pong_pkg.sv
// Shared playfield geometry, object sizes and state encodings for the Pong renderer.
// Coordinates are 10 bits; wide_t adds a carry bit for comparisons that could overflow.
package pong_pkg;

  localparam int COORD_W = 10;
  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [COORD_W:0]   wide_t;

  localparam coord_t H_ACTIVE     = 10'd640;
  localparam coord_t V_ACTIVE     = 10'd480;
  localparam coord_t PADDLE_X     = 10'd16;
  localparam coord_t PADDLE_W     = 10'd8;
  localparam coord_t PADDLE_H     = 10'd64;
  localparam coord_t PADDLE_SPEED = 10'd4;
  localparam coord_t BALL_SIZE    = 10'd8;
  localparam coord_t BALL_SPEED   = 10'd2;

  localparam int SERVE_FRAMES = 60;
  localparam int SERVE_W      = 6;
  typedef logic [SERVE_W-1:0] serve_cnt_t;
  localparam serve_cnt_t SERVE_LAST = serve_cnt_t'(SERVE_FRAMES - 1);

  localparam coord_t PADDLE_Y_MAX = V_ACTIVE - PADDLE_H;
  localparam coord_t PADDLE_Y_RST = PADDLE_Y_MAX >> 1;
  localparam coord_t BALL_X_RST   = (H_ACTIVE - BALL_SIZE) >> 1;
  localparam coord_t BALL_Y_RST   = (V_ACTIVE - BALL_SIZE) >> 1;
  localparam coord_t NET_X_LO     = 10'd319;
  localparam coord_t NET_X_HI     = 10'd320;

  typedef enum logic {SERVE = 1'b0, PLAY = 1'b1} state_t;
  // Negative direction is left / up, positive is right / down.
  typedef enum logic {DIR_NEG = 1'b0, DIR_POS = 1'b1} dir_t;

  function automatic wide_t widen(coord_t v);
    return {1'b0, v};
  endfunction

  function automatic logic inSpan(coord_t p, coord_t lo, coord_t len);
    return (widen(p) >= widen(lo)) && (widen(p) < widen(lo) + widen(len));
  endfunction

endpackage

// File: rtl/button_sync.sv
// Two-flop synchroniser bringing an asynchronous push-button into the pixel clock domain.
module button_sync (
  input  logic clk,
  input  logic reset,
  input  logic asyncIn,
  output logic syncOut
);

  logic meta;

  // NOTE: non-blocking assignments keep both flops sampling the pre-edge values, forming a true two-stage chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta    <= 1'b0;
      syncOut <= 1'b0;
    end else begin
      meta    <= asyncIn;
      syncOut <= meta;
    end
  end

endmodule

// File: rtl/pong_frame_renderer.sv
// Pong playfield renderer: game state advances once per frame in vertical blanking,
// colour is registered for one clock and the syncs are delayed to match.
import pong_pkg::*;

module pong_frame_renderer (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] counter_x,
  input  logic [9:0] counter_y,
  input  logic       in_display_area,
  input  logic       h_sync_in,
  input  logic       v_sync_in,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic       vga_r,
  output logic       vga_g,
  output logic       vga_b,
  output logic       vga_h_sync,
  output logic       vga_v_sync,
  output logic [3:0] misses
);

  logic upSync, downSync;

  button_sync upSyncInst   (.clk(clk), .reset(reset), .asyncIn(btn_up),   .syncOut(upSync));
  button_sync downSyncInst (.clk(clk), .reset(reset), .asyncIn(btn_down), .syncOut(downSync));

  state_t     state, stateNext;
  serve_cnt_t serveCnt, serveCntNext;
  coord_t     paddleY, paddleYNext;
  coord_t     ballX, ballXNext, ballY, ballYNext;
  dir_t       dirX, dirXNext, dirY, dirYNext;
  logic [3:0] missesNext;
  logic [2:0] pixelRgb, rgbQ;

  logic  frameTick;
  logic  missHit, paddleHit, rightHit, topHit, bottomHit;
  wide_t padUp, padDown;

  assign frameTick = (counter_x == '0) && (counter_y == V_ACTIVE);

  assign missHit   = (dirX == DIR_NEG) && (ballX <= BALL_SPEED);
  assign paddleHit = (dirX == DIR_NEG)
                  && (ballX >= PADDLE_X + PADDLE_W - BALL_SPEED)
                  && (ballX <= PADDLE_X + PADDLE_W)
                  && (widen(ballY) + widen(BALL_SIZE) > widen(paddleY))
                  && (widen(ballY) < widen(paddleY) + widen(PADDLE_H));
  assign rightHit  = (dirX == DIR_POS)
                  && (widen(ballX) + widen(BALL_SIZE) >= widen(H_ACTIVE - BALL_SPEED));
  assign topHit    = (dirY == DIR_NEG) && (ballY <= BALL_SPEED);
  assign bottomHit = (dirY == DIR_POS)
                  && (widen(ballY) + widen(BALL_SIZE) >= widen(V_ACTIVE - BALL_SPEED));

  // Carry bit of padUp flags an underflow past the top edge.
  assign padUp   = widen(paddleY) - widen(PADDLE_SPEED);
  assign padDown = widen(paddleY) + widen(PADDLE_SPEED);

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    paddleYNext  = paddleY;
    stateNext    = state;
    serveCntNext = serveCnt;
    ballXNext    = ballX;
    ballYNext    = ballY;
    dirXNext     = dirX;
    dirYNext     = dirY;
    missesNext   = misses;

    if (frameTick) begin
      if (upSync && !downSync) begin
        paddleYNext = padUp[COORD_W] ? '0 : padUp[COORD_W-1:0];
      end else if (downSync && !upSync) begin
        paddleYNext = (padDown > widen(PADDLE_Y_MAX)) ? PADDLE_Y_MAX : padDown[COORD_W-1:0];
      end

      if (state == SERVE) begin
        if (serveCnt == SERVE_LAST) begin
          serveCntNext = '0;
          stateNext    = PLAY;
        end else begin
          serveCntNext = serveCnt + serve_cnt_t'(1);
        end
      end else begin
        if (missHit) begin
          missesNext = misses + 4'd1;
          ballXNext  = BALL_X_RST;
          ballYNext  = BALL_Y_RST;
          dirXNext   = DIR_POS;
          stateNext  = SERVE;
        end else if (paddleHit) begin
          dirXNext = DIR_POS;
        end else if (rightHit) begin
          dirXNext = DIR_NEG;
        end

        if (topHit) begin
          dirYNext = DIR_POS;
        end else if (bottomHit) begin
          dirYNext = DIR_NEG;
        end

        if (!missHit) begin
          ballXNext = (dirXNext == DIR_POS) ? ballX + BALL_SPEED : ballX - BALL_SPEED;
          ballYNext = (dirYNext == DIR_POS) ? ballY + BALL_SPEED : ballY - BALL_SPEED;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= SERVE;
      serveCnt <= '0;
      paddleY  <= PADDLE_Y_RST;
      ballX    <= BALL_X_RST;
      ballY    <= BALL_Y_RST;
      dirX     <= DIR_POS;
      dirY     <= DIR_POS;
      misses   <= '0;
    end else begin
      state    <= stateNext;
      serveCnt <= serveCntNext;
      paddleY  <= paddleYNext;
      ballX    <= ballXNext;
      ballY    <= ballYNext;
      dirX     <= dirXNext;
      dirY     <= dirYNext;
      misses   <= missesNext;
    end
  end

  // Drawing priority: ball over paddle over centre net.
  always_comb begin
    pixelRgb = 3'b000;
    if (in_display_area) begin
      if (inSpan(counter_x, ballX, BALL_SIZE) && inSpan(counter_y, ballY, BALL_SIZE)) begin
        pixelRgb = 3'b111;
      end else if (inSpan(counter_x, PADDLE_X, PADDLE_W) && inSpan(counter_y, paddleY, PADDLE_H)) begin
        pixelRgb = 3'b010;
      end else if ((counter_x == NET_X_LO || counter_x == NET_X_HI) && !counter_y[4]) begin
        pixelRgb = 3'b001;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgbQ       <= 3'b000;
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
    end else begin
      rgbQ       <= pixelRgb;
      vga_h_sync <= h_sync_in;
      vga_v_sync <= v_sync_in;
    end
  end

  assign {vga_r, vga_g, vga_b} = rgbQ;

endmodule

// File: tb/tb_pong_frame_renderer.sv
// Directed bench for pong_frame_renderer: drives the pixel counters directly, forces frame
// ticks, and reads game state back through rendered pixels and the misses port.
module tb_pong_frame_renderer;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] counter_x, counter_y;
  logic       in_display_area, h_sync_in, v_sync_in, btn_up, btn_down;
  logic       vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync;
  logic [3:0] misses;

  int checks   = 0;
  int failures = 0;
  int tickNum  = 0;

  pong_frame_renderer dut (
    .clk(clk), .reset(reset),
    .counter_x(counter_x), .counter_y(counter_y), .in_display_area(in_display_area),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .btn_up(btn_up), .btn_down(btn_down),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .misses(misses)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  task automatic idle();
    counter_x = 10'd1; counter_y = 10'd0; in_display_area = 1'b0;
  endtask

  // One frame tick: counters sit on (0, V_ACTIVE) for exactly one rising edge.
  task automatic frameTick();
    counter_x = 10'd0; counter_y = 10'd480; in_display_area = 1'b0;
    @(negedge clk);
    idle();
    tickNum++;
  endtask

  task automatic runTo(input int n);
    while (tickNum < n) frameTick();
  endtask

  task automatic probe(input int x, input int y, input logic disp, output logic [2:0] rgb);
    counter_x = 10'(x); counter_y = 10'(y); in_display_area = disp;
    @(negedge clk);
    rgb = {vga_r, vga_g, vga_b};
    idle();
  endtask

  // Bits: two inner corners white, three neighbours just outside not white.
  task automatic ballAt(input int x, input int y, output logic [4:0] hits);
    logic [2:0] c;
    probe(x, y, 1'b1, c);         hits[0] = (c == 3'b111);
    probe(x + 7, y + 7, 1'b1, c); hits[1] = (c == 3'b111);
    probe(x - 1, y, 1'b1, c);     hits[2] = (c != 3'b111);
    probe(x + 8, y + 7, 1'b1, c); hits[3] = (c != 3'b111);
    probe(x, y + 8, 1'b1, c);     hits[4] = (c != 3'b111);
  endtask

  task automatic doReset();
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1;
    idle();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    tickNum = 0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [2:0] c;
    logic [4:0] hits;
    reset = 1'b1; btn_up = 1'b0; btn_down = 1'b0;
    counter_x = 10'd320; counter_y = 10'd240; in_display_area = 1'b1;
    h_sync_in = 1'b0; v_sync_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({vga_r, vga_g, vga_b} !== 3'b000) begin failures++; $display("FAIL reset_rgb got=%b need=000", {vga_r, vga_g, vga_b}); end
    checks++; if ({vga_h_sync, vga_v_sync} !== 2'b11) begin failures++; $display("FAIL reset_syncs got=%b need=11", {vga_h_sync, vga_v_sync}); end
    checks++; if (misses !== 4'd0) begin failures++; $display("FAIL reset_misses got=%0d need=0", misses); end
    reset = 1'b0; h_sync_in = 1'b1; v_sync_in = 1'b1; tickNum = 0;
    idle();
    @(negedge clk);

    probe(320, 240, 1'b1, c);
    checks++; if (c !== 3'b111) begin failures++; $display("FAIL centre_white got=%b need=111", c); end
    probe(320, 240, 1'b0, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL centre_blank got=%b need=000", c); end
    probe(16, 208, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL paddle_top got=%b need=010", c); end
    probe(16, 207, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL paddle_above got=%b need=000", c); end
    probe(23, 271, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL paddle_corner got=%b need=010", c); end
    probe(16, 272, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL paddle_below got=%b need=000", c); end
    probe(24, 240, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL paddle_right got=%b need=000", c); end
    probe(319, 0, 1'b1, c);
    checks++; if (c !== 3'b001) begin failures++; $display("FAIL net_on got=%b need=001", c); end
    probe(320, 47, 1'b1, c);
    checks++; if (c !== 3'b001) begin failures++; $display("FAIL net_on_hi got=%b need=001", c); end
    probe(320, 16, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL net_gap got=%b need=000", c); end
    probe(321, 0, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL net_side got=%b need=000", c); end

    frameTick();
    ballAt(316, 236, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL tick1_ball hits=%b need=11111", hits); end
    probe(16, 208, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL tick1_paddle got=%b need=010", c); end
    checks++; if (misses !== 4'd0) begin failures++; $display("FAIL tick1_misses got=%0d need=0", misses); end
  endtask

  task automatic test_sync();
    h_sync_in = 1'b0; v_sync_in = 1'b1;
    checks++; if ({vga_h_sync, vga_v_sync} !== 2'b11) begin failures++; $display("FAIL sync_pre got=%b need=11", {vga_h_sync, vga_v_sync}); end
    @(negedge clk);
    checks++; if ({vga_h_sync, vga_v_sync} !== 2'b01) begin failures++; $display("FAIL sync_h got=%b need=01", {vga_h_sync, vga_v_sync}); end
    h_sync_in = 1'b1; v_sync_in = 1'b0;
    @(negedge clk);
    checks++; if ({vga_h_sync, vga_v_sync} !== 2'b10) begin failures++; $display("FAIL sync_v got=%b need=10", {vga_h_sync, vga_v_sync}); end
    v_sync_in = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_serve();
    logic [4:0] hits;
    runTo(59);
    ballAt(316, 236, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL serve_t59 hits=%b need=11111", hits); end
    runTo(60);
    ballAt(316, 236, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL serve_t60 hits=%b need=11111", hits); end
    runTo(61);
    ballAt(318, 238, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL play_t61 hits=%b need=11111", hits); end
  endtask

  task automatic test_walls();
    logic [4:0] hits;
    runTo(177);
    ballAt(550, 470, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL bottom_t177 hits=%b need=11111", hits); end
    runTo(178);
    ballAt(552, 468, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL bottom_t178 hits=%b need=11111", hits); end
    runTo(217);
    ballAt(630, 390, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL right_t217 hits=%b need=11111", hits); end
    runTo(218);
    ballAt(628, 388, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL right_t218 hits=%b need=11111", hits); end
    runTo(412);
    ballAt(240, 4, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL top_t412 hits=%b need=11111", hits); end
  endtask

  task automatic test_paddle_hit();
    logic [2:0] c;
    logic [4:0] hits;
    runTo(520);
    ballAt(24, 220, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL hit_t520 hits=%b need=11111", hits); end
    probe(24, 220, 1'b0, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL blank_ball got=%b need=000", c); end
    probe(16, 208, 1'b0, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL blank_paddle got=%b need=000", c); end
    runTo(521);
    ballAt(26, 222, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL hit_t521 hits=%b need=11111", hits); end
    runTo(540);
    checks++; if (misses !== 4'd0) begin failures++; $display("FAIL hit_no_miss got=%0d need=0", misses); end
  endtask

  task automatic test_paddle_up_and_miss();
    logic [2:0] c;
    logic [4:0] hits;
    doReset();
    btn_up = 1'b1;
    repeat (3) @(negedge clk);
    runTo(51);
    probe(16, 4, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL up_t51_top got=%b need=010", c); end
    probe(16, 3, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL up_t51_above got=%b need=000", c); end
    runTo(52);
    probe(16, 0, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL up_t52_top got=%b need=010", c); end
    probe(16, 64, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL up_t52_below got=%b need=000", c); end
    runTo(60);
    probe(16, 63, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL up_clamp_bottom got=%b need=010", c); end
    probe(16, 64, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL up_clamp_below got=%b need=000", c); end
    btn_up = 1'b0;
    repeat (3) @(negedge clk);

    runTo(521);
    ballAt(22, 222, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL nohit_t521 hits=%b need=11111", hits); end
    runTo(531);
    ballAt(2, 242, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL miss_t531 hits=%b need=11111", hits); end
    checks++; if (misses !== 4'd0) begin failures++; $display("FAIL miss_t531_cnt got=%0d need=0", misses); end
    runTo(532);
    checks++; if (misses !== 4'd1) begin failures++; $display("FAIL miss_t532_cnt got=%0d need=1", misses); end
    ballAt(316, 236, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL miss_recentre hits=%b need=11111", hits); end
    runTo(592);
    ballAt(316, 236, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL reserve_t592 hits=%b need=11111", hits); end
    runTo(593);
    ballAt(318, 238, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL relaunch_t593 hits=%b need=11111", hits); end

    runTo(532 * 15);
    checks++; if (misses !== 4'd15) begin failures++; $display("FAIL misses_15 got=%0d need=15", misses); end
    runTo(532 * 16);
    checks++; if (misses !== 4'd0) begin failures++; $display("FAIL misses_wrap got=%0d need=0", misses); end
    ballAt(316, 236, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL wrap_recentre hits=%b need=11111", hits); end
  endtask

  task automatic test_paddle_down_and_both();
    logic [2:0] c;
    doReset();
    btn_up = 1'b1; btn_down = 1'b1;
    repeat (3) @(negedge clk);
    runTo(4);
    probe(16, 208, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL both_top got=%b need=010", c); end
    probe(16, 207, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL both_above got=%b need=000", c); end
    btn_up = 1'b0;
    repeat (3) @(negedge clk);
    runTo(55);
    probe(16, 412, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL down_t55_top got=%b need=010", c); end
    probe(16, 411, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL down_t55_above got=%b need=000", c); end
    runTo(64);
    probe(16, 416, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL down_clamp_top got=%b need=010", c); end
    probe(16, 415, 1'b1, c);
    checks++; if (c !== 3'b000) begin failures++; $display("FAIL down_clamp_above got=%b need=000", c); end
    probe(16, 479, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL down_clamp_bottom got=%b need=010", c); end
    btn_down = 1'b0;
  endtask

  task automatic test_midframe_reset();
    logic [2:0] c;
    logic [4:0] hits;
    // Tick 64 of the previous run leaves the ball at (324, 244).
    counter_x = 10'd324; counter_y = 10'd244; in_display_area = 1'b1;
    @(posedge clk);
    #2;
    checks++; if ({vga_r, vga_g, vga_b} !== 3'b111) begin failures++; $display("FAIL pre_reset_white got=%b need=111", {vga_r, vga_g, vga_b}); end
    reset = 1'b1;
    #1;
    checks++; if ({vga_r, vga_g, vga_b} !== 3'b000) begin failures++; $display("FAIL async_reset_rgb got=%b need=000", {vga_r, vga_g, vga_b}); end
    @(negedge clk);
    reset = 1'b0;
    idle();
    tickNum = 0;
    @(negedge clk);
    ballAt(316, 236, hits);
    checks++; if (hits !== 5'h1f) begin failures++; $display("FAIL post_reset_ball hits=%b need=11111", hits); end
    probe(16, 208, 1'b1, c);
    checks++; if (c !== 3'b010) begin failures++; $display("FAIL post_reset_paddle got=%b need=010", c); end
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_sync();
    test_serve();
    test_walls();
    test_paddle_hit();
    test_paddle_up_and_miss();
    test_paddle_down_and_both();
    test_midframe_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pong_frame_renderer.md
Name: pong_frame_renderer

Overview:
- Downstream consumer of the VGA sync/counter generator. Takes its pixel counters, display-enable and active-low syncs, and produces the pixel colour for the Pong playfield.
- Holds all game state: player paddle, ball position/direction, miss counter. Game state advances once per frame, during vertical blanking.
- Drives the VGA pins directly. Syncs are delayed to stay aligned with the registered colour.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- V_ACTIVE, 480, visible lines per frame
- PADDLE_X, 16, left edge column of paddle
- PADDLE_W, 8, paddle width in pixels
- PADDLE_H, 64, paddle height in pixels
- PADDLE_SPEED, 4, paddle pixels moved per frame
- BALL_SIZE, 8, ball edge length in pixels (square)
- BALL_SPEED, 2, ball pixels moved per frame on each axis
- SERVE_FRAMES, 60, frames the ball is held at centre before launch

Ports:
- clk  in  1  pixel clock, same clock as the sync generator
- reset  in  1  asynchronous, active-high
- counter_x  in  10  current pixel column
- counter_y  in  10  current line
- in_display_area  in  1  high while the pixel is visible
- h_sync_in  in  1  active-low hsync from the generator
- v_sync_in  in  1  active-low vsync from the generator
- btn_up  in  1  asynchronous button input, high = pressed
- btn_down  in  1  asynchronous button input, high = pressed
- vga_r  out  1  red
- vga_g  out  1  green
- vga_b  out  1  blue
- vga_h_sync  out  1  h_sync_in delayed 1 clk
- vga_v_sync  out  1  v_sync_in delayed 1 clk
- misses  out  4  count of balls missed, wraps 15->0

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values:
  - paddle_y = (V_ACTIVE-PADDLE_H)/2 = 208
  - ball_x = (H_ACTIVE-BALL_SIZE)/2 = 316, ball_y = (V_ACTIVE-BALL_SIZE)/2 = 236
  - dir_x = right, dir_y = down
  - state = SERVE, serve_cnt = 0, misses = 0
  - vga_r/g/b = 0, vga_h_sync = vga_v_sync = 1
- Button inputs: each passes through a 2-flop synchroniser. Both pressed, or neither pressed, means no paddle move.
- Frame tick: single-cycle pulse when counter_x==0 && counter_y==V_ACTIVE. Exactly one per frame. All game-state updates happen only on frame_tick.
- Paddle, on tick:
  - up: paddle_y -= PADDLE_SPEED, clamped at 0
  - down: paddle_y += PADDLE_SPEED, clamped at V_ACTIVE-PADDLE_H = 416
  - Computed in 11 bits, so there is no unsigned underflow.
- State SERVE:
  - Ball is held at centre.
  - serve_cnt increments on each tick.
  - When serve_cnt==SERVE_FRAMES-1 on a tick: serve_cnt clears, state becomes PLAY. The ball first moves on the next tick.
- State PLAY, on tick, evaluated in this priority order against the current position:
  1. Miss: dir_x==left && ball_x <= BALL_SPEED.
     - misses += 1, ball recentred, dir_x = right, state = SERVE.
  2. Paddle hit: dir_x==left, ball_x in [PADDLE_X+PADDLE_W-BALL_SPEED, PADDLE_X+PADDLE_W], and ball_y+BALL_SIZE > paddle_y && ball_y < paddle_y+PADDLE_H.
     - dir_x = right.
  3. Right wall: dir_x==right && ball_x+BALL_SIZE >= H_ACTIVE-BALL_SPEED.
     - dir_x = left.
  4. Top wall: dir_y==up && ball_y <= BALL_SPEED → dir_y = down.
     Bottom wall: dir_y==down && ball_y+BALL_SIZE >= V_ACTIVE-BALL_SPEED → dir_y = up.
     - Vertical checks are independent of rules 1–3.
  5. Move: unless rule 1 fired, ball moves BALL_SPEED along the updated direction on each axis.
  - Outcome: the ball never leaves [0, H_ACTIVE-BALL_SIZE] × [0, V_ACTIVE-BALL_SIZE].
- Pixel output (1-clk latency, all registered):
  - Colour is 0 when in_display_area is low.
  - Ball pixel → white (1,1,1).
  - Else paddle pixel → green (0,1,0).
  - Else column 319..320 with counter_y[4]==0 (centre net) → blue (0,0,1).
  - Else black.
- Sync alignment: vga_h_sync / vga_v_sync are registered copies of the sync inputs, so colour and sync stay aligned.
- Mid-frame reset: takes effect immediately. After deassertion, output resumes on the next clk; game resumes at the next frame_tick.

Decomposition:
- Package pong_pkg:
  - Playfield and object-size constants (H_ACTIVE, V_ACTIVE, PADDLE_*, BALL_*)
  - State encoding SERVE=1'b0, PLAY=1'b1
  - Direction encoding (dir 0 = left/up, 1 = right/down)
- One natural sub-module: button_sync (2-flop synchroniser), instantiated twice.

Test Plan:
- Reset, then run 1 frame with no buttons → paddle_y=208, ball at (316,236), state SERVE, misses=0; pixel (320,240) white one clk after it is presented.
- Hold btn_up for 60 frames → paddle_y reaches 0 after 52 ticks and stays 0; btn_up+btn_down together → paddle_y unchanged.
- Run 60 ticks → PLAY entered on tick 60; next tick ball_x=318, ball_y=238.
- Preload ball_x=630, dir right, PLAY → dir_x becomes left on that tick; next ball_x=628.
- Ball approaching left with paddle_y=0, ball_y=300 → miss at ball_x<=2, misses=1, ball recentred, SERVE for 60 frames; 16 misses → misses wraps to 0.
- Ball at ball_x=24 moving left, ball_y=220, paddle_y=208 → dir_x = right, no miss; in_display_area low → vga_r/g/b all 0 regardless of position.
